// File: rtl/cartram_saver.sv
// rtl/cartram_saver.sv - cartridge battery RAM upload engine answering hps_io ioctl reads
// Optional feature: define CARTRAM_AUTOSAVE_EN to raise upload requests after a quiet period.
module cartram_saver #(
  parameter int          RAM_AW          = 13,
  parameter logic [7:0]  UPLOAD_INDEX    = 8'h01,
  parameter logic [23:0] AUTOSAVE_CYCLES = 24'd5_000_000
) (
  input  logic              CLK,
  input  logic              RESB,
  input  logic              RAM_PRESENT,
  input  logic              RAM_WE,
  input  logic              SAVE_REQ,
  input  logic              IOCTL_UPLOAD,
  input  logic [7:0]        IOCTL_INDEX,
  input  logic              IOCTL_RD,
  input  logic [24:0]       IOCTL_ADDR,
  output logic [7:0]        IOCTL_DIN,
  output logic              IOCTL_WAIT,
  output logic              IOCTL_UPLOAD_REQ,
  output logic              RAM_REQ,
  output logic [RAM_AW-1:0] RAM_ADDR,
  input  logic              RAM_ACK,
  input  logic [7:0]        RAM_DATA
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              ram_req_q, ram_req_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              upload_req_q, upload_req_d;
  logic              dirty_q, dirty_d;
  logic              save_q;
  logic              upload_q;

  logic hit;
  logic in_range;
  logic save_rise;
  logic upload_rise;
  logic req_set;
  logic auto_fire;

  assign hit         = IOCTL_UPLOAD & IOCTL_RD & (IOCTL_INDEX == UPLOAD_INDEX);
  // Anything at or above the RAM size reads back as open bus (8'hFF).
  assign in_range    = (IOCTL_ADDR[24:RAM_AW] == '0);
  assign save_rise   = SAVE_REQ & ~save_q;
  assign upload_rise = IOCTL_UPLOAD & ~upload_q;

`ifdef CARTRAM_AUTOSAVE_EN
  logic [23:0] quiet_q, quiet_d;

  // Quiet counter: reload on every write and while uploading, count down while dirty.
  always_comb begin
    quiet_d = quiet_q;
    if (RAM_WE || IOCTL_UPLOAD) begin
      quiet_d = AUTOSAVE_CYCLES;
    end else if (dirty_q && (quiet_q != 24'd0)) begin
      quiet_d = quiet_q - 24'd1;
    end
  end

  // Quiet counter register.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      quiet_q <= AUTOSAVE_CYCLES;
    end else begin
      quiet_q <= quiet_d;
    end
  end

  assign auto_fire = dirty_q & (quiet_q == 24'd0);
`else
  logic unused_autosave;
  assign unused_autosave = ^AUTOSAVE_CYCLES;
  assign auto_fire       = 1'b0;
`endif

  assign req_set = (save_rise | auto_fire) & dirty_q & RAM_PRESENT & ~IOCTL_UPLOAD;

  // Read FSM next state and registered outputs; REQ/ADDR stay put until ACK.
  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    wait_d     = wait_q;
    ram_req_d  = ram_req_q;
    ram_addr_d = ram_addr_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (in_range) begin
            ram_req_d  = 1'b1;
            ram_addr_d = IOCTL_ADDR[RAM_AW-1:0];
            wait_d     = 1'b1;
            state_d    = S_FETCH;
          end else begin
            din_d = 8'hFF;
          end
        end
      end
      S_FETCH: begin
        if (RAM_ACK) begin
          din_d     = RAM_DATA;
          ram_req_d = 1'b0;
          wait_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Dirty flag and upload request: a write wins over the upload-start clear.
  always_comb begin
    dirty_d      = dirty_q;
    upload_req_d = upload_req_q;
    if (!RAM_PRESENT) begin
      dirty_d      = 1'b0;
      upload_req_d = 1'b0;
    end else begin
      if (RAM_WE) begin
        dirty_d = 1'b1;
      end else if (upload_rise) begin
        dirty_d = 1'b0;
      end
      if (upload_rise) begin
        upload_req_d = 1'b0;
      end else if (req_set) begin
        upload_req_d = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output, dirty and edge-detect registers.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      din_q        <= 8'h00;
      wait_q       <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_addr_q   <= '0;
      upload_req_q <= 1'b0;
      dirty_q      <= 1'b0;
      save_q       <= 1'b0;
      upload_q     <= 1'b0;
    end else begin
      din_q        <= din_d;
      wait_q       <= wait_d;
      ram_req_q    <= ram_req_d;
      ram_addr_q   <= ram_addr_d;
      upload_req_q <= upload_req_d;
      dirty_q      <= dirty_d;
      save_q       <= SAVE_REQ;
      upload_q     <= IOCTL_UPLOAD;
    end
  end

  assign IOCTL_DIN        = din_q;
  assign IOCTL_WAIT       = wait_q;
  assign IOCTL_UPLOAD_REQ = upload_req_q;
  assign RAM_REQ          = ram_req_q;
  assign RAM_ADDR         = ram_addr_q;

endmodule

// File: tb/tb_cartram_saver.sv
// tb/tb_cartram_saver.sv - directed self-checking bench for cartram_saver
module tb_cartram_saver;

  logic        CLK;
  logic        RESB;
  logic        RAM_PRESENT;
  logic        RAM_WE;
  logic        SAVE_REQ;
  logic        IOCTL_UPLOAD;
  logic [7:0]  IOCTL_INDEX;
  logic        IOCTL_RD;
  logic [24:0] IOCTL_ADDR;
  logic [7:0]  IOCTL_DIN;
  logic        IOCTL_WAIT;
  logic        IOCTL_UPLOAD_REQ;
  logic        RAM_REQ;
  logic [12:0] RAM_ADDR;
  logic        RAM_ACK;
  logic [7:0]  RAM_DATA;

  int checks   = 0;
  int failures = 0;

  cartram_saver #(
    .RAM_AW(13),
    .UPLOAD_INDEX(8'h01),
    .AUTOSAVE_CYCLES(24'd100)
  ) dut (
    .CLK(CLK),
    .RESB(RESB),
    .RAM_PRESENT(RAM_PRESENT),
    .RAM_WE(RAM_WE),
    .SAVE_REQ(SAVE_REQ),
    .IOCTL_UPLOAD(IOCTL_UPLOAD),
    .IOCTL_INDEX(IOCTL_INDEX),
    .IOCTL_RD(IOCTL_RD),
    .IOCTL_ADDR(IOCTL_ADDR),
    .IOCTL_DIN(IOCTL_DIN),
    .IOCTL_WAIT(IOCTL_WAIT),
    .IOCTL_UPLOAD_REQ(IOCTL_UPLOAD_REQ),
    .RAM_REQ(RAM_REQ),
    .RAM_ADDR(RAM_ADDR),
    .RAM_ACK(RAM_ACK),
    .RAM_DATA(RAM_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    RESB         = 1'b0;
    RAM_PRESENT  = 1'b1;
    RAM_WE       = 1'b0;
    SAVE_REQ     = 1'b0;
    IOCTL_UPLOAD = 1'b0;
    IOCTL_INDEX  = 8'h01;
    IOCTL_RD     = 1'b0;
    IOCTL_ADDR   = 25'h0;
    RAM_ACK      = 1'b0;
    RAM_DATA     = 8'h00;
    tick();
    tick();
    chk("rst_din", {24'h0, IOCTL_DIN}, 32'h00);
    chk("rst_wait", {31'h0, IOCTL_WAIT}, 32'h0);
    chk("rst_upreq", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);
    chk("rst_req", {31'h0, RAM_REQ}, 32'h0);
    chk("rst_addr", {19'h0, RAM_ADDR}, 32'h0);
    RESB = 1'b1;
    tick();

    // Single read with ack three cycles after REQ
    IOCTL_UPLOAD = 1'b1;
    tick();
    IOCTL_RD   = 1'b1;
    IOCTL_ADDR = 25'h0123;
    tick();
    IOCTL_RD = 1'b0;
    chk("rd_req", {31'h0, RAM_REQ}, 32'h1);
    chk("rd_addr", {19'h0, RAM_ADDR}, 32'h0123);
    chk("rd_wait", {31'h0, IOCTL_WAIT}, 32'h1);
    tick();
    tick();
    chk("rd_req_held", {31'h0, RAM_REQ}, 32'h1);
    chk("rd_wait_held", {31'h0, IOCTL_WAIT}, 32'h1);
    chk("rd_addr_held", {19'h0, RAM_ADDR}, 32'h0123);
    RAM_ACK  = 1'b1;
    RAM_DATA = 8'hA5;
    tick();
    RAM_ACK = 1'b0;
    chk("rd_din", {24'h0, IOCTL_DIN}, 32'hA5);
    chk("rd_req_drop", {31'h0, RAM_REQ}, 32'h0);
    chk("rd_wait_drop", {31'h0, IOCTL_WAIT}, 32'h0);

    // Out of range read
    IOCTL_RD   = 1'b1;
    IOCTL_ADDR = 25'h2000;
    tick();
    IOCTL_RD = 1'b0;
    chk("oor_din", {24'h0, IOCTL_DIN}, 32'hFF);
    chk("oor_req", {31'h0, RAM_REQ}, 32'h0);
    chk("oor_wait", {31'h0, IOCTL_WAIT}, 32'h0);
    tick();
    chk("oor_req2", {31'h0, RAM_REQ}, 32'h0);

    // Wrong index ignored
    IOCTL_INDEX = 8'h00;
    IOCTL_RD    = 1'b1;
    IOCTL_ADDR  = 25'h0010;
    tick();
    IOCTL_RD    = 1'b0;
    IOCTL_INDEX = 8'h01;
    chk("idx_req", {31'h0, RAM_REQ}, 32'h0);
    chk("idx_din", {24'h0, IOCTL_DIN}, 32'hFF);

    // Top in-range address with same-cycle ack (two-cycle latency)
    IOCTL_RD   = 1'b1;
    IOCTL_ADDR = 25'h1FFF;
    tick();
    IOCTL_RD = 1'b0;
    chk("top_req", {31'h0, RAM_REQ}, 32'h1);
    chk("top_addr", {19'h0, RAM_ADDR}, 32'h1FFF);
    RAM_ACK  = 1'b1;
    RAM_DATA = 8'h3C;
    tick();
    RAM_ACK = 1'b0;
    chk("top_din", {24'h0, IOCTL_DIN}, 32'h3C);
    chk("top_wait", {31'h0, IOCTL_WAIT}, 32'h0);
    IOCTL_UPLOAD = 1'b0;
    tick();

    // Save with nothing written does nothing
    SAVE_REQ = 1'b1;
    tick();
    tick();
    chk("clean_save", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);
    SAVE_REQ = 1'b0;
    tick();

    // Write then save raises the request, held until upload
    RAM_WE = 1'b1;
    tick();
    RAM_WE   = 1'b0;
    SAVE_REQ = 1'b1;
    tick();
    SAVE_REQ = 1'b0;
    chk("dirty_save", {31'h0, IOCTL_UPLOAD_REQ}, 32'h1);
    tick();
    tick();
    chk("req_hold", {31'h0, IOCTL_UPLOAD_REQ}, 32'h1);
    IOCTL_UPLOAD = 1'b1;
    tick();
    chk("upl_clear", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);
    // Save during an upload is not honoured
    RAM_WE = 1'b1;
    tick();
    RAM_WE   = 1'b0;
    SAVE_REQ = 1'b1;
    tick();
    SAVE_REQ = 1'b0;
    chk("save_in_upl", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);
    IOCTL_UPLOAD = 1'b0;
    tick();
    SAVE_REQ = 1'b1;
    tick();
    SAVE_REQ = 1'b0;
    chk("redirty_save", {31'h0, IOCTL_UPLOAD_REQ}, 32'h1);
    IOCTL_UPLOAD = 1'b1;
    tick();
    IOCTL_UPLOAD = 1'b0;
    tick();
    SAVE_REQ = 1'b1;
    tick();
    SAVE_REQ = 1'b0;
    chk("cleaned_save", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);

    // Write coinciding with upload start leaves dirty set
    RAM_WE       = 1'b1;
    IOCTL_UPLOAD = 1'b1;
    tick();
    RAM_WE       = 1'b0;
    IOCTL_UPLOAD = 1'b0;
    tick();
    SAVE_REQ = 1'b1;
    tick();
    SAVE_REQ = 1'b0;
    chk("same_cycle_we", {31'h0, IOCTL_UPLOAD_REQ}, 32'h1);

    // RAM_PRESENT low kills request and dirty
    RAM_PRESENT = 1'b0;
    tick();
    chk("nopresent_req", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);
    RAM_PRESENT = 1'b1;
    tick();
    SAVE_REQ = 1'b1;
    tick();
    SAVE_REQ = 1'b0;
    chk("nopresent_dirty", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);

    // Async reset in the middle of a fetch
    IOCTL_UPLOAD = 1'b1;
    IOCTL_RD     = 1'b1;
    IOCTL_ADDR   = 25'h0055;
    tick();
    IOCTL_RD = 1'b0;
    chk("ar_req_pre", {31'h0, RAM_REQ}, 32'h1);
    #2;
    RESB = 1'b0;
    #1;
    chk("ar_req", {31'h0, RAM_REQ}, 32'h0);
    chk("ar_wait", {31'h0, IOCTL_WAIT}, 32'h0);
    chk("ar_addr", {19'h0, RAM_ADDR}, 32'h0);
    chk("ar_din", {24'h0, IOCTL_DIN}, 32'h00);
    RAM_ACK  = 1'b1;
    RAM_DATA = 8'h77;
    tick();
    RESB = 1'b1;
    tick();
    RAM_ACK = 1'b0;
    chk("ar_ack_ign", {24'h0, IOCTL_DIN}, 32'h00);
    chk("ar_wait_post", {31'h0, IOCTL_WAIT}, 32'h0);
    IOCTL_UPLOAD = 1'b0;
    tick();

`ifdef CARTRAM_AUTOSAVE_EN
    // Autosave after 100 quiet cycles
    RAM_WE = 1'b1;
    tick();
    RAM_WE = 1'b0;
    n = 0;
    while (IOCTL_UPLOAD_REQ !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("auto_delay", n, 32'd101);
    IOCTL_UPLOAD = 1'b1;
    tick();
    IOCTL_UPLOAD = 1'b0;
    tick();
    // A second write restarts the quiet period
    RAM_WE = 1'b1;
    tick();
    RAM_WE = 1'b0;
    for (int i = 0; i < 49; i++) tick();
    chk("auto_early", {31'h0, IOCTL_UPLOAD_REQ}, 32'h0);
    RAM_WE = 1'b1;
    tick();
    RAM_WE = 1'b0;
    n = 50;
    while (IOCTL_UPLOAD_REQ !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("auto_delay2", n, 32'd151);
`else
    n = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
